imem_loader: RTL and testbench

// - Encodes one instruction per handshake (add, sub, lw, sw, beq) from operation class and register/immediate fields into a 32-bit MIPS word.
// - Writes the encoded words sequentially into instruction memory.
// - Writer end of the opcode/funct path that the control unit decodes; used by test harnesses and boot load.
// - Accepts a stream of instructions; stops on in_last or when memory is full.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/imem_loader_if.sv | 28 ++
 rtl/mips_instr_encode.sv | 26 ++
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, op classes and loader FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;

  // Operation class carried on in_op; 5..7 are illegal.
  typedef enum logic [2:0] {
    CLS_ADD = 3'd0,
    CLS_SUB = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4
  } op_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction stream handshake plus instruction-memory write port.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Loader side: consumes the stream, drives the memory write.
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  // Host side: produces the stream, observes the memory write.
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_instr_encode.sv
// Combinational encoder: op class + register/immediate fields -> MIPS word.
module mips_instr_encode
  import mips_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output enc_t        enc_o
);

  // Fields not used by an op class are simply left out of the word.
  always_comb begin
    enc_o = '0;
    case (op_i)
      CLS_ADD: enc_o = '{legal: 1'b1, word: {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_ADD}};
      CLS_SUB: enc_o = '{legal: 1'b1, word: {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_SUB}};
      CLS_LW:  enc_o = '{legal: 1'b1, word: {OP_LW,  rs_i, rt_i, imm_i}};
      CLS_SW:  enc_o = '{legal: 1'b1, word: {OP_SW,  rs_i, rt_i, imm_i}};
      CLS_BEQ: enc_o = '{legal: 1'b1, word: {OP_BEQ, rs_i, rt_i, imm_i}};
      default: enc_o = '0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded instructions into instruction memory, one per handshake.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  enc_t enc;
  logic accept, wr, at_end;

  mips_instr_encode u_enc (
    .op_i  (bus.in_op),
    .rs_i  (bus.in_rs),
    .rt_i  (bus.in_rt),
    .rd_i  (bus.in_rd),
    .imm_i (bus.in_imm),
    .enc_o (enc)
  );

  // start takes priority over a transfer so a restart never races an accept.
  assign bus.in_ready = (state_q == ST_LOAD) && !start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr           = accept && enc.legal;
  assign at_end       = (addr_q == ADDR_W'(DEPTH - 1));

  // Next-state logic: a load ends on in_last or on filling the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (start)                                  state_d = ST_LOAD;
        else if (accept && (bus.in_last || at_end)) state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: register the encoded word one cycle behind the accept.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = wr;
    waddr_d = addr_q;
    wdata_d = wr ? enc.word : wdata_q;
    if (start) begin
      addr_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else begin
      if (wr) begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
      if (accept && !enc.legal) err_d = 1'b1;
    end
  end

  // State and output registers; reset drops any pending write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q == ST_LOAD);
  assign done           = (state_q == ST_DONE);
  assign err_illegal    = err_q;
  assign word_count     = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: DUT A (256 words) and DUT B (4 words), scoreboarded writes.
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;
  logic [8:0] wc_a;
  logic [2:0] wc_b;

  imem_loader_if #(.ADDR_W(8)) ifa ();
  imem_loader_if #(.ADDR_W(2)) ifb ();

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .err_illegal(err_a), .word_count(wc_a)
  );

  imem_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .err_illegal(err_b), .word_count(wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  checks = 0;
  int  errors = 0;
  int  ncyc   = 0;
  int  exp_a  = 0;
  int  exp_b  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every observed write must match the head of the expected queue,
  // including the negedge index at which it was due.
  always @(negedge clk) begin
    wr_t e;
    ncyc++;
    if (ifa.imem_we === 1'b1) begin
      if (qa.size() > 0) e = qa.pop_front();
      else e = '{-1, 32'hx, -1};
      chk("a_wr_addr", 32'(ifa.imem_addr), 32'(e.addr));
      chk("a_wr_data", ifa.imem_wdata, e.data);
      chk("a_wr_cycle", 32'(ncyc), 32'(e.cyc));
    end
    if (ifb.imem_we === 1'b1) begin
      if (qb.size() > 0) e = qb.pop_front();
      else e = '{-1, 32'hx, -1};
      chk("b_wr_addr", 32'(ifb.imem_addr), 32'(e.addr));
      chk("b_wr_data", ifb.imem_wdata, e.data);
      chk("b_wr_cycle", 32'(ncyc), 32'(e.cyc));
    end
  end

  // Present one instruction for one clock edge; rdy is the expected in_ready.
  task automatic send(input bit b, input logic [2:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input bit last, input bit rdy, input bit legal, input logic [31:0] w);
    @(negedge clk); #1;
    if (!b) begin
      ifa.in_valid = 1'b1; ifa.in_op = op; ifa.in_rs = rs; ifa.in_rt = rt;
      ifa.in_rd = rd; ifa.in_imm = imm; ifa.in_last = last;
      chk("a_in_ready", 32'(ifa.in_ready), 32'(rdy));
      if (rdy && legal) begin qa.push_back('{exp_a, w, ncyc + 1}); exp_a++; end
    end else begin
      ifb.in_valid = 1'b1; ifb.in_op = op; ifb.in_rs = rs; ifb.in_rt = rt;
      ifb.in_rd = rd; ifb.in_imm = imm; ifb.in_last = last;
      chk("b_in_ready", 32'(ifb.in_ready), 32'(rdy));
      if (rdy && legal) begin qb.push_back('{exp_b, w, ncyc + 1}); exp_b++; end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk); #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  // in_valid is left as-is during the start cycle: in_ready must block it.
  task automatic pulse(input bit b);
    @(negedge clk); #1;
    if (!b) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    if (!b) exp_a = 0; else exp_b = 0;
  endtask

  initial begin
    start_a = 0; start_b = 0;
    ifa.in_valid = 0; ifa.in_op = 0; ifa.in_rs = 0; ifa.in_rt = 0;
    ifa.in_rd = 0; ifa.in_imm = 0; ifa.in_last = 0;
    ifb.in_valid = 0; ifb.in_op = 0; ifb.in_rs = 0; ifb.in_rt = 0;
    ifb.in_rd = 0; ifb.in_imm = 0; ifb.in_last = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    chk("rst_in_ready", 32'(ifa.in_ready), 0);
    chk("rst_we", 32'(ifa.imem_we), 0);
    chk("rst_addr", 32'(ifa.imem_addr), 0);
    chk("rst_wdata", ifa.imem_wdata, 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_wc", 32'(wc_a), 0);
    chk("rst_b_ready", 32'(ifb.in_ready), 0);
    @(negedge clk); #1 rst = 1'b0;

    // ADD then SUB(last)
    pulse(0);
    chk("t1_busy", 32'(busy_a), 1);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 1, 1, 32'h00221820);
    send(0, 3'd1, 5'd4, 5'd5, 5'd6, 16'h0, 1, 1, 1, 32'h00853022);
    idle();
    chk("t1_done", 32'(done_a), 1);
    chk("t1_busy_low", 32'(busy_a), 0);
    chk("t1_wc", 32'(wc_a), 2);
    chk("t1_ready_low", 32'(ifa.in_ready), 0);

    // I-type words
    pulse(0);
    send(0, 3'd2, 5'd0, 5'd8, 5'd0, 16'h0004, 0, 1, 1, 32'h8C080004);
    send(0, 3'd3, 5'd29, 5'd31, 5'd0, 16'hFFFC, 0, 1, 1, 32'hAFBFFFFC);
    send(0, 3'd4, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1, 1, 1, 32'h1022FFFF);
    idle();
    chk("t2_done", 32'(done_a), 1);
    chk("t2_wc", 32'(wc_a), 3);

    // Illegal op between two ADDs, then illegal with last
    pulse(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 1, 1, 32'h00221820);
    send(0, 3'd6, 5'd9, 5'd9, 5'd9, 16'h1234, 0, 1, 0, 32'h0);
    #1 chk("t3_err_n1", 32'(err_a), 1);
    send(0, 3'd1, 5'd4, 5'd5, 5'd6, 16'h0, 1, 1, 1, 32'h00853022);
    idle();
    chk("t3_err_sticky", 32'(err_a), 1);
    chk("t3_wc", 32'(wc_a), 2);
    chk("t3_done", 32'(done_a), 1);
    pulse(0);
    chk("t3_err_clr", 32'(err_a), 0);
    chk("t3_wc_clr", 32'(wc_a), 0);
    send(0, 3'd7, 5'd1, 5'd1, 5'd1, 16'h0, 1, 1, 0, 32'h0);
    #1;
    chk("t3_ill_last_done", 32'(done_a), 1);
    chk("t3_ill_last_err", 32'(err_a), 1);
    chk("t3_ill_last_wc", 32'(wc_a), 0);
    idle();

    // Restart mid-stream after 3 accepts
    pulse(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 1, 1, 32'h00221820);
    send(0, 3'd0, 5'd1, 5'd2, 5'd4, 16'h0, 0, 1, 1, 32'h00222020);
    send(0, 3'd0, 5'd1, 5'd2, 5'd5, 16'h0, 0, 1, 1, 32'h00222820);
    pulse(0);
    chk("t4_wc_clr", 32'(wc_a), 0);
    chk("t4_err_clr", 32'(err_a), 0);
    chk("t4_busy", 32'(busy_a), 1);
    send(0, 3'd0, 5'd7, 5'd8, 5'd9, 16'h0, 1, 1, 1, 32'h00E84820);
    idle();
    chk("t4_wc", 32'(wc_a), 1);
    chk("t4_done", 32'(done_a), 1);

    // DEPTH=4 fill without in_last
    pulse(1);
    for (int i = 0; i < 6; i++)
      send(1, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, (i < 4), 1, 32'h00221820);
    idle();
    chk("t5_done", 32'(done_b), 1);
    chk("t5_wc", 32'(wc_b), 4);
    chk("t5_ready_low", 32'(ifb.in_ready), 0);
    chk("t5_err", 32'(err_b), 0);
    idle();
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    // Reset the cycle after an accept
    pulse(0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 1, 1, 32'h00221820);
    #2 rst = 1'b1;
    #1;
    chk("t6_we", 32'(ifa.imem_we), 0);
    chk("t6_ready", 32'(ifa.in_ready), 0);
    chk("t6_addr", 32'(ifa.imem_addr), 0);
    chk("t6_wdata", ifa.imem_wdata, 0);
    chk("t6_busy", 32'(busy_a), 0);
    chk("t6_done", 32'(done_a), 0);
    chk("t6_err", 32'(err_a), 0);
    chk("t6_wc", 32'(wc_a), 0);
    qa.delete();
    qb.delete();
    @(negedge clk); #1 rst = 1'b0;
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 0, 1, 32'h0);
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0, 0, 1, 32'h0);
    #1 chk("t6_still_idle", 32'(busy_a), 0);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
